// File: rtl/sc_levelcounter_if.sv
// Control/status bundle between the game state machine and the level counter.
// The master drives the active-low strobes and enable; the slave returns level/tick status.
interface sc_levelcounter_if #(
    parameter int LEVEL_WIDTH = 3
);
    logic                   SC_LEVELCOUNTER_clear_InLow;
    logic                   SC_LEVELCOUNTER_upcount_InLow;
    logic                   SC_LEVELCOUNTER_enable_InHigh;
    logic [LEVEL_WIDTH-1:0] SC_LEVELCOUNTER_level_Out;
    logic                   SC_LEVELCOUNTER_comparator_levels_Out;
    logic                   SC_LEVELCOUNTER_speedtick_Out;
    logic                   SC_LEVELCOUNTER_levelup_Out;

    modport master (
        output SC_LEVELCOUNTER_clear_InLow,
        output SC_LEVELCOUNTER_upcount_InLow,
        output SC_LEVELCOUNTER_enable_InHigh,
        input  SC_LEVELCOUNTER_level_Out,
        input  SC_LEVELCOUNTER_comparator_levels_Out,
        input  SC_LEVELCOUNTER_speedtick_Out,
        input  SC_LEVELCOUNTER_levelup_Out
    );

    modport slave (
        input  SC_LEVELCOUNTER_clear_InLow,
        input  SC_LEVELCOUNTER_upcount_InLow,
        input  SC_LEVELCOUNTER_enable_InHigh,
        output SC_LEVELCOUNTER_level_Out,
        output SC_LEVELCOUNTER_comparator_levels_Out,
        output SC_LEVELCOUNTER_speedtick_Out,
        output SC_LEVELCOUNTER_levelup_Out
    );
endinterface

// File: rtl/sc_levelcounter.sv
// Game level counter: edge-detected level-up, final-level comparator and a
// speed tick whose period shrinks by PERIOD_STEP for every level gained.
module sc_levelcounter #(
    parameter int LEVEL_WIDTH = 3,
    parameter int MAX_LEVEL   = 4,
    parameter int TICK_WIDTH  = 24,
    parameter int BASE_PERIOD = 10000000,
    parameter int PERIOD_STEP = 2000000
) (
    input  logic                SC_LEVELCOUNTER_CLOCK_50,
    input  logic                SC_LEVELCOUNTER_RESET_InLow,
    sc_levelcounter_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_LEVELUP = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [LEVEL_WIDTH-1:0] LP_MAX        = LEVEL_WIDTH'(MAX_LEVEL);
    localparam int                     LP_NUM_LEVELS = 2 ** LEVEL_WIDTH;

    logic w_clk;
    logic w_rst_n;
    logic w_clear_n;
    logic w_upcount_n;
    logic w_enable;

    assign w_clk       = SC_LEVELCOUNTER_CLOCK_50;
    assign w_rst_n     = SC_LEVELCOUNTER_RESET_InLow;
    assign w_clear_n   = bus.SC_LEVELCOUNTER_clear_InLow;
    assign w_upcount_n = bus.SC_LEVELCOUNTER_upcount_InLow;
    assign w_enable    = bus.SC_LEVELCOUNTER_enable_InHigh;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [LEVEL_WIDTH-1:0]  r_level;
    logic [LEVEL_WIDTH-1:0]  w_level_next;
    logic                    r_comparator;
    logic                    w_comparator_next;
    logic                    r_levelup;
    logic                    w_levelup_next;
    logic [TICK_WIDTH-1:0]   r_count;
    logic [TICK_WIDTH-1:0]   w_count_next;
    logic                    r_upcount_prev;

    // Terminal count (period-1) per level; levels past MAX_LEVEL are unreachable
    // but clamp to the final period so the table stays well defined.
    logic [TICK_WIDTH-1:0]   w_last_lut [LP_NUM_LEVELS];

    genvar gi;
    generate
        for (gi = 0; gi < LP_NUM_LEVELS; gi++) begin : g_period
            localparam int LP_LVL = (gi > MAX_LEVEL) ? MAX_LEVEL : gi;
            assign w_last_lut[gi] = TICK_WIDTH'(BASE_PERIOD - LP_LVL * PERIOD_STEP - 1);
        end
    endgenerate

    logic [TICK_WIDTH-1:0]   w_count_last;
    logic                    w_tick;
    logic                    w_edge;
    logic                    w_accept;
    logic [LEVEL_WIDTH-1:0]  w_level_inc;

    assign w_count_last = w_last_lut[r_level];
    assign w_tick       = (r_state == S_RUN) && (r_count == w_count_last);
    assign w_edge       = r_upcount_prev && !w_upcount_n;
    assign w_accept     = w_edge && (r_level < LP_MAX) &&
                          ((r_state == S_IDLE) || (r_state == S_RUN));
    assign w_level_inc  = r_level + LEVEL_WIDTH'(1);

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state        <= S_IDLE;
            r_level        <= '0;
            r_comparator   <= 1'b0;
            r_levelup      <= 1'b0;
            r_count        <= '0;
            r_upcount_prev <= 1'b1;
        end else begin
            r_state        <= w_state_next;
            r_level        <= w_level_next;
            r_comparator   <= w_comparator_next;
            r_levelup      <= w_levelup_next;
            r_count        <= w_count_next;
            r_upcount_prev <= w_upcount_n;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_level_next      = r_level;
        w_comparator_next = r_comparator;
        w_levelup_next    = 1'b0;
        w_count_next      = r_count;

        if (!w_clear_n) begin
            // Clear wins over a coincident level-up edge, which is simply dropped.
            w_state_next      = S_IDLE;
            w_level_next      = '0;
            w_comparator_next = 1'b0;
            w_count_next      = '0;
        end else if (w_accept) begin
            w_state_next      = S_LEVELUP;
            w_level_next      = w_level_inc;
            w_levelup_next    = 1'b1;
            w_comparator_next = (w_level_inc == LP_MAX);
            w_count_next      = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_enable) begin
                        w_state_next = S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_tick) begin
                        w_count_next = '0;
                    end else if (w_enable) begin
                        w_count_next = r_count + TICK_WIDTH'(1);
                    end
                    if (!w_enable) begin
                        w_state_next = S_IDLE;
                    end
                end
                S_LEVELUP: begin
                    w_count_next = '0;
                    if (r_level == LP_MAX) begin
                        w_state_next = S_DONE;
                    end else if (w_enable) begin
                        w_state_next = S_RUN;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
                S_DONE: begin
                    w_count_next      = '0;
                    w_comparator_next = 1'b1;
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_count_next = '0;
                end
            endcase
        end
    end

    assign bus.SC_LEVELCOUNTER_level_Out             = r_level;
    assign bus.SC_LEVELCOUNTER_comparator_levels_Out = r_comparator;
    assign bus.SC_LEVELCOUNTER_speedtick_Out         = w_tick;
    assign bus.SC_LEVELCOUNTER_levelup_Out           = r_levelup;

endmodule

// File: tb/tb_sc_levelcounter.sv
// Directed bench for sc_levelcounter with a short tick period (10 cycles at
// level 0, minus 2 per level, final level 3).
module tb_sc_levelcounter;

    localparam int LW   = 3;
    localparam int MAXL = 3;
    localparam int TW   = 8;
    localparam int BASE = 10;
    localparam int STEP = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    sc_levelcounter_if #(.LEVEL_WIDTH(LW)) bus ();

    sc_levelcounter #(
        .LEVEL_WIDTH (LW),
        .MAX_LEVEL   (MAXL),
        .TICK_WIDTH  (TW),
        .BASE_PERIOD (BASE),
        .PERIOD_STEP (STEP)
    ) dut (
        .SC_LEVELCOUNTER_CLOCK_50    (clk),
        .SC_LEVELCOUNTER_RESET_InLow (rst_n),
        .bus                         (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int tick_cnt;
    int tick_first;
    int lu_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        $display("vec %0d %s observed=%0d expected=%0d", n_vec, tag, obs, exp);
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance n cycles, tallying speed ticks (and first tick index) and levelup pulses.
    task automatic run(input int n);
        tick_cnt   = 0;
        tick_first = 0;
        lu_cnt     = 0;
        for (int i = 1; i <= n; i++) begin
            step();
            if (bus.SC_LEVELCOUNTER_speedtick_Out === 1'b1) begin
                tick_cnt++;
                if (tick_first == 0) tick_first = i;
            end
            if (bus.SC_LEVELCOUNTER_levelup_Out === 1'b1) lu_cnt++;
        end
    endtask

    task automatic do_clear();
        bus.SC_LEVELCOUNTER_clear_InLow = 1'b0;
        step();
        bus.SC_LEVELCOUNTER_clear_InLow = 1'b1;
    endtask

    task automatic pulse(input string tag, input int exp_level, input int exp_lu);
        bus.SC_LEVELCOUNTER_upcount_InLow = 1'b0;
        step();
        chk({tag, "_levelup"}, 32'(bus.SC_LEVELCOUNTER_levelup_Out), 32'(exp_lu));
        chk({tag, "_level"},   32'(bus.SC_LEVELCOUNTER_level_Out),   32'(exp_level));
        bus.SC_LEVELCOUNTER_upcount_InLow = 1'b1;
        step();
        step();
    endtask

    initial begin
        bus.SC_LEVELCOUNTER_clear_InLow   = 1'b1;
        bus.SC_LEVELCOUNTER_upcount_InLow = 1'b1;
        bus.SC_LEVELCOUNTER_enable_InHigh = 1'b1;

        // 1: reset, release, level-0 tick period of 10
        #2 rst_n = 1'b0;
        #1;
        chk("rst_level",   32'(bus.SC_LEVELCOUNTER_level_Out), 0);
        chk("rst_comp",    32'(bus.SC_LEVELCOUNTER_comparator_levels_Out), 0);
        chk("rst_tick",    32'(bus.SC_LEVELCOUNTER_speedtick_Out), 0);
        chk("rst_levelup", 32'(bus.SC_LEVELCOUNTER_levelup_Out), 0);
        repeat (3) step();
        rst_n = 1'b1;
        chk("rel_level", 32'(bus.SC_LEVELCOUNTER_level_Out), 0);
        chk("rel_tick",  32'(bus.SC_LEVELCOUNTER_speedtick_Out), 0);
        run(10);
        chk("l0_first_tick", 32'(tick_first), 10);
        chk("l0_tick_cnt",   32'(tick_cnt), 1);
        run(10);
        chk("l0_second_tick", 32'(tick_first), 10);
        chk("l0_comp",        32'(bus.SC_LEVELCOUNTER_comparator_levels_Out), 0);

        // 2: one-cycle upcount in RUN (coinciding with a tick), then period 8
        bus.SC_LEVELCOUNTER_upcount_InLow = 1'b0;
        step();
        chk("up1_level",   32'(bus.SC_LEVELCOUNTER_level_Out), 1);
        chk("up1_levelup", 32'(bus.SC_LEVELCOUNTER_levelup_Out), 1);
        chk("up1_tick",    32'(bus.SC_LEVELCOUNTER_speedtick_Out), 0);
        bus.SC_LEVELCOUNTER_upcount_InLow = 1'b1;
        run(20);
        chk("l1_first_tick", 32'(tick_first), 8);
        chk("l1_tick_cnt",   32'(tick_cnt), 2);
        chk("l1_lu_cnt",     32'(lu_cnt), 0);

        // 3: upcount held low for 5 cycles gives a single increment
        do_clear();
        chk("clr3_level", 32'(bus.SC_LEVELCOUNTER_level_Out), 0);
        bus.SC_LEVELCOUNTER_upcount_InLow = 1'b0;
        run(5);
        chk("hold_lu_cnt", 32'(lu_cnt), 1);
        bus.SC_LEVELCOUNTER_upcount_InLow = 1'b1;
        run(5);
        chk("hold_lu_after", 32'(lu_cnt), 0);
        chk("hold_level",    32'(bus.SC_LEVELCOUNTER_level_Out), 1);

        // 4: climb to the final level, DONE holds and ignores further edges
        do_clear();
        pulse("p1", 1, 1);
        pulse("p2", 2, 1);
        chk("p2_comp", 32'(bus.SC_LEVELCOUNTER_comparator_levels_Out), 0);
        pulse("p3", 3, 1);
        chk("p3_comp", 32'(bus.SC_LEVELCOUNTER_comparator_levels_Out), 1);
        run(30);
        chk("done_tick_cnt", 32'(tick_cnt), 0);
        chk("done_comp",     32'(bus.SC_LEVELCOUNTER_comparator_levels_Out), 1);
        pulse("p4", 3, 0);

        // 5: clear and upcount edge in the same cycle at level 2
        do_clear();
        chk("clr5_comp", 32'(bus.SC_LEVELCOUNTER_comparator_levels_Out), 0);
        pulse("q1", 1, 1);
        pulse("q2", 2, 1);
        bus.SC_LEVELCOUNTER_clear_InLow   = 1'b0;
        bus.SC_LEVELCOUNTER_upcount_InLow = 1'b0;
        step();
        chk("clrup_level",   32'(bus.SC_LEVELCOUNTER_level_Out), 0);
        chk("clrup_comp",    32'(bus.SC_LEVELCOUNTER_comparator_levels_Out), 0);
        chk("clrup_levelup", 32'(bus.SC_LEVELCOUNTER_levelup_Out), 0);
        bus.SC_LEVELCOUNTER_clear_InLow = 1'b1;
        step();
        chk("clrhist_levelup", 32'(bus.SC_LEVELCOUNTER_levelup_Out), 0);
        chk("clrhist_level",   32'(bus.SC_LEVELCOUNTER_level_Out), 0);
        bus.SC_LEVELCOUNTER_upcount_InLow = 1'b1;
        step();
        pulse("q3", 1, 1);

        // 6: enable dropped at count 4, counter frozen, resumes from 4
        do_clear();
        repeat (5) step();
        bus.SC_LEVELCOUNTER_enable_InHigh = 1'b0;
        run(20);
        chk("dis_tick_cnt", 32'(tick_cnt), 0);
        bus.SC_LEVELCOUNTER_enable_InHigh = 1'b1;
        run(20);
        chk("reen_first_tick", 32'(tick_first), 6);
        chk("reen_tick_cnt",   32'(tick_cnt), 2);

        // async reset while a level-1 tick is visible
        pulse("r1", 1, 1);
        repeat (6) step();
        chk("pre_rst_tick", 32'(bus.SC_LEVELCOUNTER_speedtick_Out), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_level", 32'(bus.SC_LEVELCOUNTER_level_Out), 0);
        chk("mid_rst_tick",  32'(bus.SC_LEVELCOUNTER_speedtick_Out), 0);
        chk("mid_rst_comp",  32'(bus.SC_LEVELCOUNTER_comparator_levels_Out), 0);
        #2 rst_n = 1'b1;
        run(12);
        chk("post_rst_first_tick", 32'(tick_first), 10);
        chk("post_rst_level",      32'(bus.SC_LEVELCOUNTER_level_Out), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
